// File: rtl/bcd_scan_display_if.sv
// Bus between an arithmetic datapath and the BCD scan display block.
interface bcd_scan_display_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]  bin_in;
   logic              load;
   logic              signed_mode;
   logic              blank_lz;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (
      output bin_in, load, signed_mode, blank_lz,
      input  busy, done, ovf, seg, an
   );

   modport slave (
      input  bin_in, load, signed_mode, blank_lz,
      output busy, done, ovf, seg, an
   );
endinterface

// File: rtl/bcd_scan_display.sv
// Iterative double-dabble binary-to-BCD converter driving a multiplexed,
// active-low 7-segment display with optional sign and leading-zero blanking.
module bcd_scan_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000
) (
   input logic               clk,
   input logic               rst_n,
   bcd_scan_display_if.slave io
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONV   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   // Nibble code marking a top digit replaced by the minus sign on overflow.
   localparam logic [3:0] MINUS_CODE = 4'hF;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mag;
   logic [BW-1:0]    r_bcd;
   logic             r_negc;
   logic             r_lost;
   logic [BW-1:0]    r_disp;
   logic             r_neg;
   logic             r_ovf;
   logic             r_done;
   logic [PW-1:0]    r_pre;
   logic [IW-1:0]    r_idx;

   logic             w_accept;
   logic             w_neg_in;
   logic [WIDTH-1:0] w_mag_in;
   logic [BW-1:0]    w_adj;
   logic             w_ovf_nxt;
   logic [BW-1:0]    w_disp_nxt;
   logic [IW-1:0]    w_msd;
   logic [IW-1:0]    w_mpos;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg;
   logic [DIGITS-1:0] w_an;

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'b1000000;
         4'd1:    f_decode = 7'b1111001;
         4'd2:    f_decode = 7'b0100100;
         4'd3:    f_decode = 7'b0110000;
         4'd4:    f_decode = 7'b0011001;
         4'd5:    f_decode = 7'b0010010;
         4'd6:    f_decode = 7'b0000010;
         4'd7:    f_decode = 7'b1111000;
         4'd8:    f_decode = 7'b0000000;
         4'd9:    f_decode = 7'b0010000;
         default: f_decode = 7'b1111111;
      endcase
   endfunction

   assign w_accept = (r_state == ST_IDLE) && io.load;
   assign w_neg_in = io.signed_mode && io.bin_in[WIDTH-1];
   assign w_mag_in = w_neg_in ? (~io.bin_in + WIDTH'(1)) : io.bin_in;

   always_comb begin
      w_adj = r_bcd;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_ovf_nxt  = r_lost | (r_negc & (|r_bcd[BW-1 -: 4]));
      w_disp_nxt = r_bcd;
      if (r_negc && w_ovf_nxt) w_disp_nxt[BW-1 -: 4] = MINUS_CODE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_mag   <= '0;
         r_bcd   <= '0;
         r_negc  <= 1'b0;
         r_lost  <= 1'b0;
         r_disp  <= '0;
         r_neg   <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_CONV;
                  r_cnt   <= '0;
                  r_mag   <= w_mag_in;
                  r_bcd   <= '0;
                  r_negc  <= w_neg_in;
                  r_lost  <= 1'b0;
               end
            end
            ST_CONV: begin
               r_bcd  <= {w_adj[BW-2:0], r_mag[WIDTH-1]};
               r_mag  <= {r_mag[WIDTH-2:0], 1'b0};
               r_lost <= r_lost | w_adj[BW-1];
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               r_disp  <= w_disp_nxt;
               r_neg   <= r_negc;
               r_ovf   <= w_ovf_nxt;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (r_pre == PW'(SCAN_DIV - 1)) begin
         r_pre <= '0;
         r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   // Minus sits just above the most significant digit when blanking, else at the top.
   always_comb begin
      w_msd = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (r_disp[i*4 +: 4] != 4'd0) w_msd = IW'(i);
      end
      if (io.blank_lz && (int'(w_msd) + 1 < DIGITS)) w_mpos = w_msd + IW'(1);
      else                                           w_mpos = IW'(DIGITS - 1);
   end

   always_comb begin
      w_digit = '0;
      w_an    = '1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (IW'(i) == r_idx) begin
            w_digit = r_disp[i*4 +: 4];
            w_an[i] = 1'b0;
         end
      end
      if (r_neg && (r_idx == w_mpos))          w_seg = 7'b0111111;
      else if (io.blank_lz && (r_idx > w_msd)) w_seg = 7'b1111111;
      else                                     w_seg = f_decode(w_digit);
   end

   assign io.busy = (r_state != ST_IDLE);
   assign io.done = r_done;
   assign io.ovf  = r_ovf;
   assign io.seg  = w_seg;
   assign io.an   = w_an;
endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Parametrised successor to the fixed 3-digit adder display path. Accepts a WIDTH-bit binary value on a one-cycle load strobe and converts it to BCD with an iterative multi-cycle double-dabble engine. Supports optional two's-complement sign display and leading-zero blanking, and drives a DIGITS-wide multiplexed, active-low 7-segment display. Sits between any arithmetic datapath and the board display pins, replacing the combinational BCD, frequency-divider and anode-select chain.

## Interface
- WIDTH, 8, binary input width (≥2)
- DIGITS, 3, number of display digits (≥2)
- SCAN_DIV, 50000, clk cycles each digit stays lit (≥1)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bin_in  in  WIDTH  value to display
- load  in  1  one-cycle strobe; accepted only when busy=0
- signed_mode  in  1  sampled with load; 1 = treat bin_in as two's complement
- blank_lz  in  1  live; 1 = blank leading zeros
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when new value is committed to the display
- ovf  out  1  last committed value did not fit in DIGITS (sticky until next commit)
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  DIGITS  one-hot active-low anode select

## Operation
- FSM states:
  - IDLE → CONV on accepted load
  - CONV lasts exactly WIDTH cycles → COMMIT
  - COMMIT lasts 1 cycle → IDLE
- Capture on accepted load:
  - mag = bin_in, neg = 0
  - if signed_mode and bin_in[WIDTH-1]=1: mag = two's-complement negation of bin_in (WIDTH bits; 1000…0 negates to itself, read unsigned), neg = 1
- CONV, each cycle: every BCD nibble ≥5 gets +3, then {bcd, mag} shifts left by 1. Any 1 shifted out of the top nibble sets an internal lost flag.
- COMMIT: load display register with BCD digits and neg, and set ovf as follows.
  - ovf = lost | (neg & top digit ≠ 0)
  - if neg and ovf: top digit is forced to minus
- Display rendering:
  - msd = index of highest nonzero digit (0 if all zero)
  - digit i blanked (seg=1111111) if blank_lz=1 and i>msd and i≠minus position; digit 0 is never blanked
  - minus position when neg:
    - msd+1 if blank_lz=1 and msd+1<DIGITS
    - otherwise DIGITS-1
  - minus pattern 0111111
  - decode active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Scanning: a prescaler counts 0..SCAN_DIV-1. At terminal count the digit index advances 0→1→…→DIGITS-1→0. an = ~(1<<index). seg shows the rendered digit for the current index, combinationally from the registered index and display register. Scanning runs continuously, independent of the FSM.
- Display register changes only at COMMIT, so old contents stay shown during CONV.

## Timing
- Reset (asynchronous, immediate):
  - FSM IDLE, busy=0, done=0, ovf=0
  - display register all zero, neg=0
  - prescaler=0, index=0
  - an = all ones except an[0]=0; seg=1000000
- Load sampled high at edge 0 with busy=0:
  - busy=1 after edge 0
  - shifts at edges 1..WIDTH
  - commit at edge WIDTH+1: display and ovf update, done=1 for that cycle only, busy=0
- Latency: load to new display is WIDTH+1 cycles. Next load can be accepted at edge WIDTH+2.
- load while busy=1 (including the COMMIT cycle's preceding edges) is ignored, with no queuing.
- Changes to bin_in or signed_mode outside the accepting edge have no effect.
- rst_n asserted mid-conversion aborts: no done pulse, display cleared to 0.
- Index advance and commit on the same edge: both take effect; the new index shows the new data.

## Test plan
Bench uses WIDTH=8, DIGITS=3, SCAN_DIV=4.
- Reset: pulse rst_n low mid-cycle → outputs change without waiting for a clock edge; an=110, seg=1000000, busy=0, ovf=0; blank_lz=1 keeps digits 1,2 at 1111111 across scan.
- Unsigned max: load 8'd255, signed_mode=0, blank_lz=0 → busy high 9 cycles, done pulse at edge 9. Scan gives an=110/seg=0010010, an=101/seg=0010010, an=011/seg=0100100, each for 4 cycles, then wraps; ovf=0.
- Signed small: load 8'hF9, signed_mode=1. With blank_lz=1 → digit0 1111000, digit1 0111111, digit2 1111111. With blank_lz=0 (toggled live) → digit1 1000000, digit2 0111111.
- Signed overflow: load 8'h80, signed_mode=1 → ovf=1, digits 8,2 shown (0000000, 0100100), digit2 0111111.
- Busy rejection: load 8'd42, then load 8'd99 at edge 3 → single done at edge 9, display 042 (or 42 with blanking), no second busy period.
- Abort: load 8'd200, assert rst_n low at edge 5 → busy=0 immediately, no done pulse, display shows 0; a fresh load 8'd7 after release gives done 9 cycles later.
